// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants and types for the VGA timing decoder: default timing sets
//   (1024x768 and 800x600), counter widths, the lock FSM state type and
//   saturating increment helpers for the horizontal and vertical counters.
package vga_timing_pkg;

  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 11;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int MATCH_W = 4;

  // 1024x768@60: 1344 strobes/line (136 sync + 160 back porch), 806 lines (6 + 29)
  localparam int XGA_H_SYNC_TO_ACTIVE  = 296;
  localparam int XGA_H_ACTIVE          = 1024;
  localparam int XGA_V_SYNC_TO_ACTIVE  = 35;
  localparam int XGA_V_ACTIVE          = 768;

  // 800x600@60: 1056 strobes/line (128 sync + 88 back porch), 628 lines (4 + 23)
  localparam int SVGA_H_SYNC_TO_ACTIVE = 216;
  localparam int SVGA_H_ACTIVE         = 800;
  localparam int SVGA_V_SYNC_TO_ACTIVE = 27;
  localparam int SVGA_V_ACTIVE         = 600;

  localparam int DEF_LOCK_FRAMES       = 2;
  localparam int DEF_H_TIMEOUT         = 4095;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_TRACKING = 2'd1,
    LK_LOCKED   = 2'd2
  } lock_st_e;

  function automatic logic [H_CNT_W-1:0] sat_inc_h(input logic [H_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [V_CNT_W-1:0] sat_inc_v(input logic [V_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge
//   Strobe-qualified sampler with rising-edge detect for one sync line.
//   The previous level is captured on every strobe; the edge is reported
//   combinationally during the strobe so the parent can register its
//   consequences on that same clock.
//   Ports:
//     i_clk   base clock
//     i_rst   synchronous active-high reset
//     i_stb   pixel strobe, sampling only when high
//     i_sig   sync input (active high)
//     o_rise  high for the strobe cycle in which a 0->1 transition is seen
module vga_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_primed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev   <= 1'b0;
      r_primed <= 1'b0;
    end else if (i_stb) begin
      r_prev   <= i_sig;
      r_primed <= 1'b1;
    end
  end

  // No edge on the first strobe after reset: a sync already high when reset
  // drops is mid-pulse, not a fresh rising edge.
  assign o_rise = i_stb && r_primed && i_sig && !r_prev;

endmodule

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
//   Recovers pixel position, active window and frame boundaries from HS/VS and
//   the pixel strobe; measures line length / lines per frame and declares lock
//   after LOCK_FRAMES consecutive matching frames.
//   Ports:
//     i_clk, i_rst        base clock, synchronous active-high reset
//     i_pix_clk           pixel strobe; all sampling/counting only when high
//     i_hs, i_vs          active-high syncs
//     o_x, o_y            recovered position, 0 outside the active window
//     o_active            inside active window and locked
//     o_locked            timing stable
//     o_line_len          strobes between the last two HS rising edges
//     o_frame_lines       HS rising edges between the last two frame starts
//     o_frame_start       one-clock pulse at line 0
//     o_err               one-clock pulse on lock loss
module vga_timing_decoder import vga_timing_pkg::*; #(
  parameter int H_SYNC_TO_ACTIVE = XGA_H_SYNC_TO_ACTIVE,
  parameter int H_ACTIVE         = XGA_H_ACTIVE,
  parameter int V_SYNC_TO_ACTIVE = XGA_V_SYNC_TO_ACTIVE,
  parameter int V_ACTIVE         = XGA_V_ACTIVE,
  parameter int LOCK_FRAMES      = DEF_LOCK_FRAMES,
  parameter int H_TIMEOUT        = DEF_H_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_clk,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_active,
  output logic        o_locked,
  output logic [11:0] o_line_len,
  output logic [10:0] o_frame_lines,
  output logic        o_frame_start,
  output logic        o_err
);

  localparam logic [H_CNT_W-1:0] LP_H_LO = H_CNT_W'(H_SYNC_TO_ACTIVE);
  localparam logic [H_CNT_W-1:0] LP_H_HI = H_CNT_W'(H_SYNC_TO_ACTIVE + H_ACTIVE);
  localparam logic [V_CNT_W-1:0] LP_V_LO = V_CNT_W'(V_SYNC_TO_ACTIVE);
  localparam logic [V_CNT_W-1:0] LP_V_HI = V_CNT_W'(V_SYNC_TO_ACTIVE + V_ACTIVE);
  localparam logic [H_CNT_W-1:0] LP_TO   = H_CNT_W'(H_TIMEOUT);
  localparam logic [MATCH_W-1:0] LP_LOCK = MATCH_W'(LOCK_FRAMES);

  logic               w_hs_rise, w_vs_rise, w_line0, w_timeout, w_win;
  logic [H_CNT_W-1:0] w_h_nxt, w_len_new, w_h_off;
  logic [V_CNT_W-1:0] w_v_nxt, w_lines_new, w_v_off;

  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;
  logic               r_vs_pend;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_active, r_locked, r_frame_start, r_err;
  logic [H_CNT_W-1:0] r_line_len;
  logic [V_CNT_W-1:0] r_frame_lines;

  // Lock FSM state and its next-state companions
  lock_st_e           r_st, w_st_nxt;
  logic [H_CNT_W-1:0] r_ref_len, w_ref_len_nxt;
  logic [V_CNT_W-1:0] r_ref_lines, w_ref_lines_nxt;
  logic [MATCH_W-1:0] r_match, w_match_nxt, w_match_inc;
  logic               r_armed, w_armed_nxt, w_err_nxt;

  vga_sync_edge u_hs_edge (
    .i_clk (i_clk), .i_rst (i_rst), .i_stb (i_pix_clk), .i_sig (i_hs), .o_rise (w_hs_rise)
  );

  vga_sync_edge u_vs_edge (
    .i_clk (i_clk), .i_rst (i_rst), .i_stb (i_pix_clk), .i_sig (i_vs), .o_rise (w_vs_rise)
  );

  // A VS rise arms line 0; it lands on the same HS rise when both edges coincide.
  assign w_line0     = w_hs_rise && (r_vs_pend || w_vs_rise);
  assign w_len_new   = sat_inc_h(r_h_cnt);
  assign w_lines_new = sat_inc_v(r_v_cnt);
  assign w_h_nxt     = w_hs_rise ? '0 : sat_inc_h(r_h_cnt);
  assign w_v_nxt     = w_line0   ? '0 : (w_hs_rise ? sat_inc_v(r_v_cnt) : r_v_cnt);
  assign w_timeout   = i_pix_clk && !w_hs_rise && (w_h_nxt >= LP_TO);

  // Window is judged on the post-update counts so outputs match this strobe.
  assign w_win   = (w_h_nxt >= LP_H_LO) && (w_h_nxt < LP_H_HI) &&
                   (w_v_nxt >= LP_V_LO) && (w_v_nxt < LP_V_HI);
  assign w_h_off = w_h_nxt - LP_H_LO;
  assign w_v_off = w_v_nxt - LP_V_LO;
  assign w_match_inc = r_match + 1'b1;

  always_comb begin
    w_st_nxt        = r_st;
    w_ref_len_nxt   = r_ref_len;
    w_ref_lines_nxt = r_ref_lines;
    w_match_nxt     = r_match;
    w_armed_nxt     = r_armed;
    w_err_nxt       = 1'b0;
    if (i_pix_clk) begin
      case (r_st)
        LK_UNLOCKED: begin
          if (w_line0) begin
            // The first line 0 after reset closes a partial frame: only arm.
            if (r_armed) begin
              w_ref_len_nxt   = w_len_new;
              w_ref_lines_nxt = w_lines_new;
              w_match_nxt     = MATCH_W'(1);
              w_st_nxt        = (LP_LOCK <= MATCH_W'(1)) ? LK_LOCKED : LK_TRACKING;
            end else begin
              w_armed_nxt = 1'b1;
            end
          end
        end
        LK_TRACKING: begin
          if (w_timeout) begin
            w_st_nxt = LK_UNLOCKED;
          end else if (w_line0) begin
            if (w_len_new == r_ref_len && w_lines_new == r_ref_lines) begin
              w_match_nxt = w_match_inc;
              if (w_match_inc >= LP_LOCK) w_st_nxt = LK_LOCKED;
            end else begin
              w_ref_len_nxt   = w_len_new;
              w_ref_lines_nxt = w_lines_new;
              w_match_nxt     = MATCH_W'(1);
            end
          end
        end
        LK_LOCKED: begin
          if (w_timeout ||
              (w_hs_rise && w_len_new != r_ref_len) ||
              (w_line0 && w_lines_new != r_ref_lines)) begin
            w_st_nxt  = LK_UNLOCKED;
            w_err_nxt = 1'b1;
          end
        end
        default: w_st_nxt = LK_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st        <= LK_UNLOCKED;
      r_ref_len   <= '0;
      r_ref_lines <= '0;
      r_match     <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_ref_len   <= w_ref_len_nxt;
      r_ref_lines <= w_ref_lines_nxt;
      r_match     <= w_match_nxt;
      r_armed     <= w_armed_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_vs_pend     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_active      <= 1'b0;
      r_locked      <= 1'b0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Both pulse sources are strobe-qualified, so they last one clock.
      r_frame_start <= w_line0;
      r_err         <= w_err_nxt;
      if (i_pix_clk) begin
        r_h_cnt <= w_h_nxt;
        r_v_cnt <= w_v_nxt;
        if (w_hs_rise) r_line_len <= w_len_new;
        if (w_line0) begin
          r_frame_lines <= w_lines_new;
          r_vs_pend     <= 1'b0;
        end else if (w_vs_rise) begin
          r_vs_pend     <= 1'b1;
        end
        r_x      <= w_win ? X_W'(w_h_off) : '0;
        r_y      <= w_win ? Y_W'(w_v_off) : '0;
        r_locked <= (w_st_nxt == LK_LOCKED);
        r_active <= w_win && (w_st_nxt == LK_LOCKED);
      end
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_active      = r_active;
  assign o_locked      = r_locked;
  assign o_line_len    = r_line_len;
  assign o_frame_lines = r_frame_lines;
  assign o_frame_start = r_frame_start;
  assign o_err         = r_err;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench on a scaled-down timing (28-strobe lines, 10-line frames)
// so full lock/relock sequences fit in a few thousand clocks.
module tb_vga_timing_decoder;

  localparam int HSA  = 6;   // H_SYNC_TO_ACTIVE
  localparam int HA   = 16;  // H_ACTIVE
  localparam int HTOT = 28;
  localparam int HSW  = 2;   // HS high strobes at line start
  localparam int VSA  = 3;   // V_SYNC_TO_ACTIVE
  localparam int VA   = 5;   // V_ACTIVE
  localparam int VTOT = 10;
  localparam int VSW  = 2;   // VS high lines at frame start
  localparam int HTO  = 60;  // H_TIMEOUT

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_pix_clk = 1'b0;
  logic        i_hs = 1'b0;
  logic        i_vs = 1'b0;
  logic [10:0] o_x;
  logic [9:0]  o_y;
  logic        o_active, o_locked, o_frame_start, o_err;
  logic [11:0] o_line_len;
  logic [10:0] o_frame_lines;

  int total = 0;
  int bad = 0;
  int fs_cnt = 0;
  int err_cnt = 0;

  vga_timing_decoder #(
    .H_SYNC_TO_ACTIVE (HSA), .H_ACTIVE (HA), .V_SYNC_TO_ACTIVE (VSA),
    .V_ACTIVE (VA), .LOCK_FRAMES (2), .H_TIMEOUT (HTO)
  ) dut (
    .i_clk (i_clk), .i_rst (i_rst), .i_pix_clk (i_pix_clk), .i_hs (i_hs), .i_vs (i_vs),
    .o_x (o_x), .o_y (o_y), .o_active (o_active), .o_locked (o_locked),
    .o_line_len (o_line_len), .o_frame_lines (o_frame_lines),
    .o_frame_start (o_frame_start), .o_err (o_err)
  );

  always #5 i_clk = ~i_clk;

  // One strobe at line position h of line l; returns 1 time unit after the
  // sampling edge with the strobe already dropped.
  task automatic pix(input int h, input int l);
    @(negedge i_clk);
    i_hs = (h < HSW);
    i_vs = (l < VSW);
    i_pix_clk = 1'b1;
    @(posedge i_clk);
    #1;
    i_pix_clk = 1'b0;
    if (o_frame_start) fs_cnt++;
    if (o_err) err_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic line_from(input int l, input int h0);
    for (int h = h0; h < HTOT; h++) pix(h, l);
  endtask

  task automatic send_lines(input int l0, input int l1);
    for (int l = l0; l <= l1; l++) line_from(l, 0);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (o_x !== 11'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", o_x); end
    total++; if (o_y !== 10'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", o_y); end
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", o_active); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", o_locked); end
    total++; if (o_line_len !== 12'd0) begin bad++; $display("FAIL reset_line_len: got %0d want 0", o_line_len); end
    total++; if (o_frame_lines !== 11'd0) begin bad++; $display("FAIL reset_frame_lines: got %0d want 0", o_frame_lines); end
    total++; if (o_frame_start !== 1'b0 || o_err !== 1'b0) begin bad++; $display("FAIL reset_pulses: got fs=%b err=%b want 0 0", o_frame_start, o_err); end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Frame 1 from reset has no line 0 (syncs already high on the first strobe);
  // line-0 #1 only arms, #2 captures, #3 locks.
  task automatic test_lock;
    send_lines(0, VTOT-1);
    total++; if (fs_cnt !== 0) begin bad++; $display("FAIL lock_no_fs_frame1: got %0d want 0", fs_cnt); end
    send_lines(0, VTOT-1);
    send_lines(0, VTOT-1);
    total++; if (fs_cnt !== 2) begin bad++; $display("FAIL lock_fs_count: got %0d want 2", fs_cnt); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", o_locked); end
    pix(0, 0);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL lock_at_3rd_line0: got %b want 1", o_locked); end
    total++; if (o_frame_start !== 1'b1) begin bad++; $display("FAIL lock_fs_pulse: got %b want 1", o_frame_start); end
    total++; if (o_line_len !== 12'd28) begin bad++; $display("FAIL lock_line_len: got %0d want 28", o_line_len); end
    total++; if (o_frame_lines !== 11'd10) begin bad++; $display("FAIL lock_frame_lines: got %0d want 10", o_frame_lines); end
    line_from(0, 1);
  endtask

  task automatic test_active;
    for (int l = 1; l < VTOT; l++) begin
      for (int h = 0; h < HTOT; h++) begin
        pix(h, l);
        if (l == 2 && h == 10) begin
          total++; if (o_active !== 1'b0) begin bad++; $display("FAIL act_above: got %b want 0", o_active); end
        end
        if (l == VSA && h == HSA) begin
          total++; if (o_x !== 11'd0 || o_y !== 10'd0 || o_active !== 1'b1) begin bad++;
            $display("FAIL act_first: got x=%0d y=%0d a=%b want 0 0 1", o_x, o_y, o_active); end
        end
        if (l == VSA && h == HSA + HA - 1) begin
          total++; if (o_x !== 11'd15 || o_active !== 1'b1) begin bad++;
            $display("FAIL act_last_x: got x=%0d a=%b want 15 1", o_x, o_active); end
        end
        if (l == VSA && h == HSA + HA) begin
          total++; if (o_x !== 11'd0 || o_active !== 1'b0) begin bad++;
            $display("FAIL act_after_x: got x=%0d a=%b want 0 0", o_x, o_active); end
        end
        if (l == 7 && h == 10) begin
          total++; if (o_x !== 11'd4 || o_y !== 10'd4 || o_active !== 1'b1) begin bad++;
            $display("FAIL act_last_y: got x=%0d y=%0d a=%b want 4 4 1", o_x, o_y, o_active); end
        end
        if (l == 8 && h == 10) begin
          total++; if (o_y !== 10'd0 || o_active !== 1'b0) begin bad++;
            $display("FAIL act_below: got y=%0d a=%b want 0 0", o_y, o_active); end
        end
      end
    end
  endtask

  task automatic test_short_line;
    int e0;
    e0 = err_cnt;
    pix(0, 0);
    line_from(0, 1);
    send_lines(1, 3);
    for (int h = 0; h < HTOT - 1; h++) pix(h, 4);   // 27-strobe line
    pix(0, 5);
    total++; if (o_locked !== 1'b0 || o_err !== 1'b1) begin bad++;
      $display("FAIL short_loss: got locked=%b err=%b want 0 1", o_locked, o_err); end
    total++; if (o_line_len !== 12'd27) begin bad++; $display("FAIL short_len: got %0d want 27", o_line_len); end
    for (int h = 1; h <= HSA; h++) pix(h, 5);
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL short_active: got %b want 0", o_active); end
    line_from(5, HSA + 1);
    send_lines(6, VTOT-1);
    pix(0, 0);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL short_relock_early: got %b want 0", o_locked); end
    line_from(0, 1);
    send_lines(1, VTOT-1);
    pix(0, 0);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL short_relock: got %b want 1", o_locked); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL short_err_count: got %0d want %0d", err_cnt, e0 + 1); end
    line_from(0, 1);
    send_lines(1, VTOT-1);
  endtask

  // HS held low on line 2: h_cnt = h, so the timeout lands on the h == HTO strobe.
  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    send_lines(0, 1);
    for (int h = 0; h < HTO; h++) pix(h, 2);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL to_before: got %b want 1", o_locked); end
    pix(HTO, 2);
    total++; if (o_locked !== 1'b0 || o_err !== 1'b1) begin bad++;
      $display("FAIL to_loss: got locked=%b err=%b want 0 1", o_locked, o_err); end
    for (int h = HTO + 1; h <= HTO + 10; h++) pix(h, 2);
    send_lines(3, VTOT-1);
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL to_single_err: got %0d want %0d", err_cnt, e0 + 1); end
    pix(0, 0);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL to_relock_early: got %b want 0", o_locked); end
    line_from(0, 1);
    send_lines(1, VTOT-1);
    pix(0, 0);
    total++; if (o_locked !== 1'b1 || o_line_len !== 12'd28) begin bad++;
      $display("FAIL to_relock: got locked=%b len=%0d want 1 28", o_locked, o_line_len); end
    line_from(0, 1);
    send_lines(1, VTOT-1);
  endtask

  task automatic test_gap;
    for (int l = 0; l < VTOT; l++) begin
      for (int h = 0; h < HTOT; h++) begin
        pix(h, l);
        if (l == 4 && h == 10) begin
          total++; if (o_x !== 11'd4 || o_y !== 10'd1 || o_active !== 1'b1) begin bad++;
            $display("FAIL gap_pos: got x=%0d y=%0d a=%b want 4 1 1", o_x, o_y, o_active); end
        end
        idle(5);
        if (l == 4 && h == 10) begin
          total++; if (o_x !== 11'd4 || o_y !== 10'd1 || o_active !== 1'b1) begin bad++;
            $display("FAIL gap_hold: got x=%0d y=%0d a=%b want 4 1 1", o_x, o_y, o_active); end
        end
      end
    end
    pix(0, 0);
    total++; if (o_line_len !== 12'd28 || o_frame_lines !== 11'd10) begin bad++;
      $display("FAIL gap_counts: got len=%0d lines=%0d want 28 10", o_line_len, o_frame_lines); end
    total++; if (o_locked !== 1'b1 || o_frame_start !== 1'b1) begin bad++;
      $display("FAIL gap_lock: got locked=%b fs=%b want 1 1", o_locked, o_frame_start); end
  endtask

  task automatic test_reset_mid;
    int f0;
    line_from(0, 1);
    send_lines(1, 3);
    for (int h = 0; h < 10; h++) pix(h, 4);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    total++; if (o_x !== 11'd0 || o_y !== 10'd0 || o_active !== 1'b0 || o_locked !== 1'b0) begin bad++;
      $display("FAIL mid_rst_pos: got x=%0d y=%0d a=%b l=%b want 0 0 0 0", o_x, o_y, o_active, o_locked); end
    total++; if (o_line_len !== 12'd0 || o_frame_lines !== 11'd0) begin bad++;
      $display("FAIL mid_rst_counts: got len=%0d lines=%0d want 0 0", o_line_len, o_frame_lines); end
    f0 = fs_cnt;
    line_from(4, 10);
    send_lines(5, VTOT-1);
    total++; if (fs_cnt !== f0 || o_frame_lines !== 11'd0) begin bad++;
      $display("FAIL mid_rst_no_fs: got fs=%0d lines=%0d want %0d 0", fs_cnt, o_frame_lines, f0); end
    // h_cnt restarts at the first post-reset strobe; HS rises on lines 5..9 give 5
    pix(0, 0);
    total++; if (o_frame_start !== 1'b1 || o_frame_lines !== 11'd6) begin bad++;
      $display("FAIL mid_rst_first_fs: got fs=%b lines=%0d want 1 6", o_frame_start, o_frame_lines); end
    total++; if (o_locked !== 1'b0 || o_line_len !== 12'd28) begin bad++;
      $display("FAIL mid_rst_state: got locked=%b len=%0d want 0 28", o_locked, o_line_len); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_active;
    test_short_line;
    test_timeout;
    test_gap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
